nibble_serial_subtractor: RTL and testbench
===========================================

Name: nibble_serial_subtractor

Overview:
- Multi-cycle 16-bit subtractor: Diff = A - B - Bin.
- Processes one 4-bit nibble per clock, LSB first, with a single 4-bit subtract slice and a registered borrow chain.
- Start/done handshake; one result every NSTEPS+1 cycles.
- Serves as the subtract path beside the 16-bit ripple adder in the arithmetic datapath, for area-constrained use.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of NIB.
- NIB, 4, bits processed per cycle.
- NSTEPS is derived, not a parameter: NSTEPS = WIDTH/NIB (default 4).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- A  input  WIDTH  minuend; captured on accepted start.
- B  input  WIDTH  subtrahend; captured on accepted start.
- Bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse; results valid.
- Diff  output  WIDTH  result register.
- Borrow  output  1  borrow out of MSB (1 = A < B + Bin, unsigned).
- Overflow  output  1  signed (two's complement) overflow.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; busy=0, done=0, Diff=0, Borrow=0, Overflow=0.
  - Internal operand/shift registers, step counter and borrow register cleared.
  - rst has priority over every other input.
- States: IDLE, CALC, DONE.
- IDLE:
  - busy=0, done=0.
  - On start=1 at edge E0: capture A, B, Bin into internal registers; step=0; borrow register=Bin; go to CALC.
- CALC (busy=1):
  - Each edge computes nibble[step] = A_nib - B_nib - borrow (NIB+1-bit arithmetic).
  - The low NIB bits go into the working result; the borrow register takes the nibble borrow out; step increments.
  - After the edge with step=NSTEPS-1 (edge E4 by default), go to DONE.
  - start is ignored throughout CALC.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0.
  - Diff, Borrow and Overflow are registered on the transition edge into DONE, so they are valid in the same cycle done=1.
  - start=1 during DONE is accepted, as in IDLE, and gives back-to-back operation; otherwise go to IDLE.
- Latency:
  - start sampled at E0; done high in the cycle following E4.
  - Throughput is one result per 5 cycles (NSTEPS+1).
- Result outputs:
  - Diff, Borrow and Overflow hold their values until the next transition into DONE.
  - They never show partial results during CALC.
- Overflow = (borrow into bit WIDTH-1) XOR (borrow out of bit WIDTH-1), computed inside the final nibble step.
- Arithmetic is exact modulo 2^WIDTH, and Bin is included.
- Boundary cases:
  - A=B, Bin=0 gives Diff=0, Borrow=0.
  - A=0, B=0, Bin=1 gives Diff=all-ones, Borrow=1.
  - The borrow must ripple correctly across all nibble boundaries in a single operation.
- Reset mid-operation: rst during CALC or DONE aborts the operation; no done pulse is produced; outputs return to reset values.
- Input handling: inputs are not required to be held after the accepted start. Changing A, B or Bin during CALC must not affect the result.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then rst=0 with start=0 for 10 cycles -> busy=0, done=0, Diff=0x0000, Borrow=0, Overflow=0 throughout.
- Basic subtract: A=0x1234, B=0x0234, Bin=0, start pulse at E0 -> done=1 exactly in the cycle after E4, Diff=0x1000, Borrow=0, Overflow=0; busy=1 for cycles E0..E4.
- Cross-nibble borrow and underflow:
  - 0x1000-0x0001 -> Diff=0x0FFF, Borrow=0.
  - 0x0000-0x0001 -> Diff=0xFFFF, Borrow=1, Overflow=0.
  - 0x0010-0x0000 with Bin=1 -> Diff=0x000F, Borrow=0.
- Signed overflow:
  - 0x8000-0x0001 -> Diff=0x7FFF, Overflow=1, Borrow=0.
  - 0x7FFF-0xFFFF -> Diff=0x8000, Overflow=1, Borrow=1.
- Handshake rules:
  - start held high, and A/B changed every cycle during CALC -> the first result uses only the E0-captured operands.
  - start=1 in the DONE cycle with 0x0005-0x0003 -> second done exactly 5 cycles after the first, Diff=0x0002.
- Reset mid-op: start 0xFFFF-0x0001, assert rst after E2 -> no done pulse; all outputs 0; a subsequent start 0x0009-0x0004 gives Diff=0x0005 normally.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
// Area-lean 16-bit subtractor: Diff = A - B - Bin, one NIB-bit slice per clock, LSB first.
// Start/done handshake; results registered on entry to DONE and held until the next result.
module nibble_serial_subtractor #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NIB   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow,
    output logic             Overflow
);

    localparam int unsigned NSTEPS = WIDTH / NIB;
    localparam int unsigned SW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam int unsigned NW     = NIB + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [SW-1:0]    step;
    logic             brw;

    logic [NW-1:0]    slice;
    logic [NIB-1:0]   low_slice;
    logic [WIDTH-1:0] res_next;

    // One subtract slice; the narrower slice exposes the borrow into the nibble MSB for overflow.
    always_comb begin
        slice     = {1'b0, a_sh[NIB-1:0]} - {1'b0, b_sh[NIB-1:0]} - NW'(brw);
        low_slice = {1'b0, a_sh[NIB-2:0]} - {1'b0, b_sh[NIB-2:0]} - NIB'(brw);
        res_next  = res_sh;
        res_next[int'(step) * int'(NIB) +: NIB] = slice[NIB-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            Diff     <= '0;
            Borrow   <= 1'b0;
            Overflow <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            step     <= '0;
            brw      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    busy <= 1'b0;
                    if (start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        brw    <= Bin;
                        res_sh <= '0;
                        step   <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    a_sh   <= a_sh >> NIB;
                    b_sh   <= b_sh >> NIB;
                    res_sh <= res_next;
                    brw    <= slice[NIB];
                    step   <= step + SW'(1);
                    // Final slice: publish the full result together with the done pulse.
                    if (step == SW'(NSTEPS - 1)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        Diff     <= res_next;
                        Borrow   <= slice[NIB];
                        Overflow <= slice[NIB] ^ low_slice[NIB-1];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Randomized and directed bench for nibble_serial_subtractor against a plain-arithmetic model.
module tb_nibble_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        borrow;
    logic        overflow;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    nibble_serial_subtractor #(.WIDTH(16), .NIB(4)) dut (
        .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Bin(bin),
        .busy(busy), .done(done), .Diff(diff), .Borrow(borrow), .Overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: 17-bit unsigned difference and signed integer range test.
    function automatic void model(input logic [15:0] av, input logic [15:0] bv, input logic c,
                                  output logic [15:0] d, output logic br, output logic ov);
        logic [16:0] f;
        int          s;
        f  = {1'b0, av} - {1'b0, bv} - 17'(c);
        d  = f[15:0];
        br = f[16];
        s  = int'($signed(av)) - int'($signed(bv)) - int'(c);
        ov = (s < -32768) || (s > 32767);
    endfunction

    // Issues one operation from IDLE or DONE; returns edges from E0 to done (-1 on timeout).
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic c,
                         input bit scramble, output int lat, output int busy_bad,
                         output logic [15:0] d, output logic br, output logic ov);
        a = av; b = bv; bin = c; start = 1'b1;
        @(posedge clk); #1;
        busy_bad = (busy !== 1'b1) ? 1 : 0;
        if (!scramble) start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (scramble) begin
                a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            end
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = i;
                if (busy !== 1'b0) busy_bad++;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
        start = 1'b0;
        d = diff; br = borrow; ov = overflow;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if ({busy, done, diff, borrow, overflow} !== 19'd0)
                $display("FAIL reset_idle cyc%0d: busy=%b done=%b diff=%h borrow=%b ovf=%b, required all 0",
                         i, busy, done, diff, borrow, overflow);
            else passed++;
        end
    endtask

    task automatic test_vectors();
        logic [15:0] va [7]  = '{16'h1234, 16'h1000, 16'h0000, 16'h0010, 16'h8000, 16'h7FFF, 16'hA5A5};
        logic [15:0] vb [7]  = '{16'h0234, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'hFFFF, 16'hA5A5};
        logic        vc [7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [15:0] ed [7]  = '{16'h1000, 16'h0FFF, 16'hFFFF, 16'h000F, 16'h7FFF, 16'h8000, 16'h0000};
        logic        eb [7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        eo [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat, bb;
        logic [15:0] d;
        logic br, ov;
        for (int i = 0; i < 7; i++) begin
            do_op(va[i], vb[i], vc[i], 1'b0, lat, bb, d, br, ov);
            total++;
            if (lat !== 4 || bb !== 0)
                $display("FAIL vec%0d_timing: latency=%0d busy_errs=%0d, required 4 and 0", i, lat, bb);
            else passed++;
            total++;
            if ({d, br, ov} !== {ed[i], eb[i], eo[i]})
                $display("FAIL vec%0d_result %h-%h-%b: got %h/%b/%b, required %h/%b/%b",
                         i, va[i], vb[i], vc[i], d, br, ov, ed[i], eb[i], eo[i]);
            else passed++;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_hold_start();
        int lat, bb;
        logic [15:0] d;
        logic br, ov;
        do_op(16'h4321, 16'h1111, 1'b1, 1'b1, lat, bb, d, br, ov);
        total++;
        if (lat !== 4 || d !== 16'h320F || br !== 1'b0)
            $display("FAIL hold_start: latency=%0d diff=%h borrow=%b, required 4 320f 0", lat, d, br);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat, bb, c1;
        logic [15:0] d;
        logic br, ov;
        do_op(16'h0100, 16'h0001, 1'b0, 1'b0, lat, bb, d, br, ov);
        c1 = cyc;
        do_op(16'h0005, 16'h0003, 1'b0, 1'b0, lat, bb, d, br, ov);
        total++;
        if (cyc - c1 !== 5 || lat !== 4)
            $display("FAIL back_to_back_spacing: %0d cycles, required 5", cyc - c1);
        else passed++;
        total++;
        if (d !== 16'h0002 || br !== 1'b0 || ov !== 1'b0)
            $display("FAIL back_to_back_result: got %h/%b/%b, required 0002/0/0", d, br, ov);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        int lat, bb, seen;
        logic [15:0] d;
        logic br, ov;
        do_op(16'h1234, 16'h0001, 1'b0, 1'b0, lat, bb, d, br, ov);
        a = 16'hFFFF; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        total++;
        if ({busy, done, diff, borrow, overflow} !== 19'd0)
            $display("FAIL midop_reset_outputs: busy=%b done=%b diff=%h borrow=%b ovf=%b, required all 0",
                     busy, done, diff, borrow, overflow);
        else passed++;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL midop_no_done: %0d active cycles, required 0", seen);
        else passed++;
        do_op(16'h0009, 16'h0004, 1'b0, 1'b0, lat, bb, d, br, ov);
        total++;
        if (lat !== 4 || d !== 16'h0005 || br !== 1'b0)
            $display("FAIL midop_recover: latency=%0d diff=%h borrow=%b, required 4 0005 0", lat, d, br);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat, bb;
        logic [15:0] av, bv, d, ed;
        logic c, br, ov, eb, eo;
        for (int i = 0; i < 40; i++) begin
            av = 16'($urandom); bv = 16'($urandom); c = 1'($urandom);
            if (i % 8 == 0) bv = av;
            model(av, bv, c, ed, eb, eo);
            do_op(av, bv, c, 1'($urandom), lat, bb, d, br, ov);
            total++;
            if (lat !== 4 || bb !== 0 || {d, br, ov} !== {ed, eb, eo})
                $display("FAIL rand%0d %h-%h-%b: lat=%0d busy_errs=%0d got %h/%b/%b, required 4/0 %h/%b/%b",
                         i, av, bv, c, lat, bb, d, br, ov, ed, eb, eo);
            else passed++;
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold_start();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
